dmem_mmio: RTL and testbench

- Data-side memory subsystem directly downstream of the single-cycle RV32I core.
- Consumes the core's MemWrite, ALUResult (address), WriteData and the instruction funct3 field.
- Returns ReadData combinationally in the same cycle.
- Contains a byte-addressable data RAM, a GPIO output register, a free-running timer with a compare interrupt flag, and a buffered byte-wide TX port with a valid/ready handshake toward an external consumer (UART or testbench).

---
 rtl/dmem_mmio_pkg.sv | 59 +++++
 rtl/dmem_mmio_tx_fifo.sv | 78 +++++++
 rtl/dmem_mmio.sv | 188 ++++++++++++++++++
 tb/tb_dmem_mmio.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants, access-size encodings and load extraction for the
// data-side memory / MMIO block.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [4:0] OFF_GPIO_OUT  = 5'h00;
    localparam logic [4:0] OFF_TIMER     = 5'h04;
    localparam logic [4:0] OFF_TIMER_CMP = 5'h08;
    localparam logic [4:0] OFF_STATUS    = 5'h0C;
    localparam logic [4:0] OFF_TX_DATA   = 5'h10;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_op_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_op_e;

    localparam int ST_IRQ     = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

    // Misaligned halves/words fall back to the aligned lane selection.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] res_s;
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            LB:      res_s = {{24{byte_s[7]}}, byte_s};
            LBU:     res_s = {24'h00_0000, byte_s};
            LH:      res_s = {{16{half_s[15]}}, half_s};
            LHU:     res_s = {16'h0000, half_s};
            default: res_s = word;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte FIFO feeding the TX valid/ready port; pushes to a full FIFO are
// dropped unless a pop frees a slot on the same edge.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {(AW+1){1'b0}});
    assign full  = (count_r == FULL_CNT);
    assign count = count_r;
    assign head  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Accept/drop decision for this cycle's push and pop.
    always_comb begin
        do_pop_s       = pop && !empty;
        do_push_s      = 1'b0;
        overflow_pulse = 1'b0;
        if (push) begin
            if (!full || do_pop_s) begin
                do_push_s = 1'b1;
            end else begin
                overflow_pulse = 1'b1;
            end
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale entries are harmless because head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory plus MMIO (GPIO, timer/compare IRQ, buffered TX port) behind
// the single-cycle core; loads are combinational, stores land on the edge.
module dmem_mmio #(
    parameter int DMEM_WORDS = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] WriteData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    import dmem_mmio_pkg::*;

    localparam int IDX_W = $clog2(DMEM_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram_r [DMEM_WORDS];
    logic [31:0]      gpio_r;
    logic [31:0]      timer_r;
    logic [31:0]      timer_cmp_r;
    logic             irq_r;
    logic             overflow_r;

    logic             is_mmio_s;
    logic [4:0]       off_s;
    logic [IDX_W-1:0] word_idx_s;
    logic             wr_gpio_s;
    logic             wr_timer_s;
    logic             wr_cmp_s;
    logic             wr_status_s;
    logic             wr_tx_s;
    logic [3:0]       ram_be_s;
    logic [31:0]      ram_wdata_s;
    logic [31:0]      status_s;
    logic [31:0]      word_s;
    logic [3:0]       cnt_field_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             ovf_pulse_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             unused_addr_s;

    assign is_mmio_s     = (addr[31] == MMIO_BASE[31]);
    assign off_s         = addr[4:0];
    assign word_idx_s    = addr[IDX_W+1:2];
    assign unused_addr_s = ^addr[30:IDX_W+2];

    // MMIO store strobes; full WriteData is used regardless of funct3.
    always_comb begin
        wr_gpio_s   = 1'b0;
        wr_timer_s  = 1'b0;
        wr_cmp_s    = 1'b0;
        wr_status_s = 1'b0;
        wr_tx_s     = 1'b0;
        if (MemWrite && is_mmio_s) begin
            case (off_s)
                OFF_GPIO_OUT:  wr_gpio_s   = 1'b1;
                OFF_TIMER:     wr_timer_s  = 1'b1;
                OFF_TIMER_CMP: wr_cmp_s    = 1'b1;
                OFF_STATUS:    wr_status_s = 1'b1;
                OFF_TX_DATA:   wr_tx_s     = 1'b1;
                default:       wr_gpio_s   = 1'b0;
            endcase
        end else begin
            wr_gpio_s = 1'b0;
        end
    end

    // RAM byte enables and lane-replicated store data.
    always_comb begin
        ram_be_s    = 4'b0000;
        ram_wdata_s = WriteData;
        if (MemWrite && !is_mmio_s) begin
            case (funct3)
                SB: begin
                    ram_be_s    = 4'b0001 << addr[1:0];
                    ram_wdata_s = {4{WriteData[7:0]}};
                end
                SH: begin
                    ram_be_s    = addr[1] ? 4'b1100 : 4'b0011;
                    ram_wdata_s = {2{WriteData[15:0]}};
                end
                SW:      ram_be_s = 4'b1111;
                default: ram_be_s = 4'b0000;
            endcase
        end else begin
            ram_be_s = 4'b0000;
        end
    end

    // Data RAM; deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_be_s[b]) begin
                ram_r[word_idx_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
            end
        end
    end

    // GPIO, timer, compare, sticky IRQ and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpio_r      <= 32'h0000_0000;
            timer_r     <= 32'h0000_0000;
            timer_cmp_r <= 32'hFFFF_FFFF;
            irq_r       <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_gpio_s) begin
                gpio_r <= WriteData;
            end
            timer_r <= wr_timer_s ? WriteData : timer_r + 32'd1;
            if (wr_cmp_s) begin
                timer_cmp_r <= WriteData;
            end
            // A set and a clear on the same edge leave the flag set.
            if (timer_r == timer_cmp_r) begin
                irq_r <= 1'b1;
            end else if (wr_status_s && WriteData[ST_IRQ]) begin
                irq_r <= 1'b0;
            end
            if (ovf_pulse_s) begin
                overflow_r <= 1'b1;
            end else if (wr_status_s && WriteData[ST_OVF]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (wr_tx_s),
        .push_data      (WriteData[7:0]),
        .pop            (tx_ready),
        .head           (tx_data),
        .full           (fifo_full_s),
        .empty          (fifo_empty_s),
        .count          (fifo_count_s),
        .overflow_pulse (ovf_pulse_s)
    );

    assign cnt_field_s = ST_CNT_W'(fifo_count_s);

    // STATUS read view.
    always_comb begin
        status_s                            = 32'h0000_0000;
        status_s[ST_IRQ]                    = irq_r;
        status_s[ST_FULL]                   = fifo_full_s;
        status_s[ST_EMPTY]                  = fifo_empty_s;
        status_s[ST_OVF]                    = overflow_r;
        status_s[ST_CNT_LSB +: ST_CNT_W]    = cnt_field_s;
    end

    // Word select from pre-edge state, then size/sign extraction.
    always_comb begin
        word_s = 32'h0000_0000;
        if (!is_mmio_s) begin
            word_s = ram_r[word_idx_s];
        end else begin
            case (off_s)
                OFF_GPIO_OUT:  word_s = gpio_r;
                OFF_TIMER:     word_s = timer_r;
                OFF_TIMER_CMP: word_s = timer_cmp_r;
                OFF_STATUS:    word_s = status_s;
                default:       word_s = 32'h0000_0000;
            endcase
        end
        ReadData = load_extract(word_s, addr[1:0], funct3);
    end

    assign gpio_out  = gpio_r;
    assign timer_irq = irq_r;
    assign tx_valid  = !fifo_empty_s;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: byte-level reference model compared every
// cycle, plus hand-computed literal expectations along the stimulus.
module tb_dmem_mmio;

    localparam logic [2:0]  F_B   = 3'b000;
    localparam logic [2:0]  F_H   = 3'b001;
    localparam logic [2:0]  F_W   = 3'b010;
    localparam logic [2:0]  F_BU  = 3'b100;
    localparam logic [2:0]  F_HU  = 3'b101;
    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_TMR  = 32'h8000_0004;
    localparam logic [31:0] A_CMP  = 32'h8000_0008;
    localparam logic [31:0] A_STAT = 32'h8000_000C;
    localparam logic [31:0] A_TXD  = 32'h8000_0010;
    localparam logic [31:0] A_IDLE = 32'h8000_0014;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        rst_n;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] WriteData;
    logic [2:0]  funct3;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    dmem_mmio #(.DMEM_WORDS(256), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .addr(addr),
        .WriteData(WriteData), .funct3(funct3), .ReadData(ReadData),
        .gpio_out(gpio_out), .timer_irq(timer_irq), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mb [1024];
    bit          kn [1024];
    logic [31:0] m_gpio, m_timer, m_cmp;
    bit          m_irq, m_ovf, model_ok;
    logic [7:0]  q [$];
    bit          mm_pop, mm_set, mm_st;
    int          mm_sz, mm_base;

    initial begin
        model_ok = 1'b0;
        for (int i = 0; i < 1024; i++) kn[i] = 1'b0;
    end

    function automatic logic [31:0] m_status();
        return {24'd0, 4'(q.size()), m_ovf, (q.size() == 0), (q.size() == DEPTH), m_irq};
    endfunction

    function automatic bit rd_known(input logic [31:0] a);
        int base;
        if (a[31]) return 1'b1;
        base = int'(a[9:2]) * 4;
        return kn[base] && kn[base+1] && kn[base+2] && kn[base+3];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        logic [7:0]  bv;
        logic [15:0] hv;
        int base;
        if (!a[31]) begin
            base = int'(a[9:2]) * 4;
            w = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
        end else begin
            case (a[4:0])
                5'h00:   w = m_gpio;
                5'h04:   w = m_timer;
                5'h08:   w = m_cmp;
                5'h0C:   w = m_status();
                default: w = 32'd0;
            endcase
        end
        bv = 8'(w >> (8 * int'(a[1:0])));
        hv = 16'(w >> (16 * int'(a[1])));
        case (f3)
            F_B:     return 32'($signed(bv));
            F_BU:    return 32'(bv);
            F_H:     return 32'($signed(hv));
            F_HU:    return 32'(hv);
            default: return w;
        endcase
    endfunction

    // Model advances on each rising edge using the inputs present before it.
    always @(posedge clk) begin
        if (MemWrite && !addr[31]) begin
            mm_base = int'(addr[9:0]);
            if (funct3 == F_B) begin
                mb[mm_base] = WriteData[7:0]; kn[mm_base] = 1'b1;
            end else if (funct3 == F_H) begin
                mm_base = (mm_base / 2) * 2;
                mb[mm_base] = WriteData[7:0]; mb[mm_base+1] = WriteData[15:8];
                kn[mm_base] = 1'b1; kn[mm_base+1] = 1'b1;
            end else if (funct3 == F_W) begin
                mm_base = (mm_base / 4) * 4;
                for (int k = 0; k < 4; k++) begin
                    mb[mm_base+k] = 8'(WriteData >> (8 * k)); kn[mm_base+k] = 1'b1;
                end
            end
        end
        if (!rst_n) begin
            m_gpio = 32'd0; m_timer = 32'd0; m_cmp = 32'hFFFF_FFFF;
            m_irq = 1'b0; m_ovf = 1'b0; q.delete(); model_ok = 1'b1;
        end else begin
            mm_set = (m_timer == m_cmp);
            mm_st  = MemWrite && addr[31] && (addr[4:0] == 5'h0C);
            mm_sz  = q.size();
            mm_pop = (mm_sz > 0) && tx_ready;
            if (MemWrite && addr[31] && addr[4:0] == 5'h04) m_timer = WriteData;
            else m_timer = m_timer + 32'd1;
            if (MemWrite && addr[31] && addr[4:0] == 5'h00) m_gpio = WriteData;
            if (MemWrite && addr[31] && addr[4:0] == 5'h08) m_cmp = WriteData;
            if (mm_st && WriteData[0]) m_irq = 1'b0;
            if (mm_set) m_irq = 1'b1;
            if (mm_st && WriteData[3]) m_ovf = 1'b0;
            if (mm_pop) void'(q.pop_front());
            if (MemWrite && addr[31] && addr[4:0] == 5'h10) begin
                if (mm_sz < DEPTH || mm_pop) q.push_back(WriteData[7:0]);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_gpio_out", gpio_out, m_gpio);
            chk("m_timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
            chk("m_tx_valid", {31'd0, tx_valid}, {31'd0, (q.size() > 0)});
            chk("m_tx_data", {24'd0, tx_data}, {24'd0, (q.size() > 0) ? q[0] : 8'h00});
            if (rd_known(addr)) chk("m_ReadData", ReadData, model_read(addr, funct3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        MemWrite = we; addr = a; WriteData = wd; funct3 = f3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drv(1'b0, A_IDLE, 32'd0, F_W);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        drv(1'b1, a, wd, f3);
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] f3, input string name, input logic [31:0] exp);
        drv(1'b0, a, 32'd0, f3);
        #1;
        chk(name, ReadData, exp);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; tx_ready = 1'b0;
        drv(1'b0, A_IDLE, 32'd0, F_W);
        tick(); tick();
        rst_n = 1'b1;

        chk("rst_gpio", gpio_out, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_txd", {24'd0, tx_data}, 32'd0);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        rd(A_STAT, F_W, "rst_status", 32'h0000_0004);
        rd(A_CMP, F_W, "rst_cmp", 32'hFFFF_FFFF);

        // RAM loads/stores
        wr(32'h10, 32'h1122_3344, F_W);
        rd(32'h13, F_B,  "lb13",  32'h0000_0011);
        rd(32'h10, F_B,  "lb10",  32'h0000_0044);
        rd(32'h12, F_H,  "lh12",  32'h0000_1122);
        rd(32'h10, F_HU, "lhu10", 32'h0000_3344);
        rd(32'h10, F_W,  "lw10",  32'h1122_3344);
        rd(32'h13, F_BU, "lbu13", 32'h0000_0011);
        wr(32'h11, 32'h0000_0080, F_B);
        rd(32'h11, F_B,  "lb11",  32'hFFFF_FF80);
        rd(32'h11, F_BU, "lbu11", 32'h0000_0080);
        rd(32'h13, F_W,  "lw13_misal", 32'h1122_8044);
        rd(32'h11, F_H,  "lh11_misal", 32'hFFFF_8044);
        wr(32'h12, 32'h0000_BEEF, F_H);
        rd(32'h12, F_HU, "lhu12", 32'h0000_BEEF);
        rd(32'h10, F_W,  "lw_sh", 32'hBEEF_8044);
        wr(32'h10, 32'hFFFF_FFFF, 3'b011);
        rd(32'h10, 3'b111, "f3_other", 32'hBEEF_8044);
        rd(32'h410, F_W, "alias", 32'hBEEF_8044);
        wr(32'h3FC, 32'hCAFE_F00D, F_W);
        rd(32'h7FFF_FFFC, F_W, "top_word", 32'hCAFE_F00D);
        wr(32'h20, 32'h1122_3344, F_W);

        // Timer compare and IRQ
        wr(A_TMR, 32'h0000_0100, F_W);
        wr(A_CMP, 32'h0000_0005, F_W);
        wr(A_TMR, 32'h0000_0000, F_W);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("irq_early", {31'd0, timer_irq}, 32'd0);
        end
        tick();
        chk("irq_match", {31'd0, timer_irq}, 32'd1);
        wr(A_STAT, 32'h0000_0001, F_W);
        chk("irq_clear", {31'd0, timer_irq}, 32'd0);
        rd(A_TMR, F_W, "timer_a", 32'd7);
        rd(A_TMR, F_W, "timer_b", 32'd8);
        wr(A_TMR, 32'h0000_0004, F_W);
        tick();
        wr(A_STAT, 32'h0000_0001, F_W);
        chk("irq_set_wins", {31'd0, timer_irq}, 32'd1);
        wr(A_STAT, 32'h0000_0001, F_W);
        chk("irq_clear2", {31'd0, timer_irq}, 32'd0);

        // FIFO fill, overflow, drain
        for (int k = 0; k < 4; k++) wr(A_TXD, 32'h0000_00A1 + 32'(k), F_B);
        chk("fill_txv", {31'd0, tx_valid}, 32'd1);
        chk("fill_head", {24'd0, tx_data}, 32'h0000_00A1);
        rd(A_STAT, F_W, "status_full", 32'h0000_0042);
        wr(A_TXD, 32'h0000_00A5, F_W);
        rd(A_STAT, F_W, "status_ovf", 32'h0000_004A);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_txv", {31'd0, tx_valid}, 32'd1);
            chk("drain_data", {24'd0, tx_data}, 32'h0000_00A1 + 32'(k));
            tick();
        end
        chk("drain_empty", {31'd0, tx_valid}, 32'd0);
        wr(A_STAT, 32'h0000_0008, F_W);
        rd(A_STAT, F_W, "ovf_clear", 32'h0000_0004);
        drv(1'b1, A_TXD, 32'h0000_00C1, F_W);
        #1;
        chk("no_bypass", {31'd0, tx_valid}, 32'd0);
        tick();
        chk("push_empty", {23'd0, tx_valid, tx_data}, 32'h0000_01C1);
        tick();
        chk("c1_gone", {31'd0, tx_valid}, 32'd0);

        // Full with simultaneous pop
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) wr(A_TXD, 32'h0000_00D1 + 32'(k), F_W);
        tx_ready = 1'b1;
        wr(A_TXD, 32'h0000_00B0, F_W);
        tx_ready = 1'b0;
        rd(A_STAT, F_W, "full_pop_push", 32'h0000_0042);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp_data", {24'd0, tx_data}, (k == 3) ? 32'h0000_00B0 : 32'h0000_00D2 + 32'(k));
            tick();
        end
        chk("fp_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // GPIO, unmapped offsets, mid-run reset
        wr(A_GPIO, 32'hDEAD_BEEF, F_B);
        chk("gpio", gpio_out, 32'hDEAD_BEEF);
        rd(A_IDLE, F_W, "unmapped_rd", 32'd0);
        wr(32'h8000_0018, 32'h1234_5678, F_W);
        chk("unmapped_wr", gpio_out, 32'hDEAD_BEEF);
        rd(A_GPIO, F_B, "gpio_lb", 32'hFFFF_FFEF);
        wr(A_TXD, 32'h0000_00E1, F_W);
        chk("pre_rst_txv", {31'd0, tx_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_gpio", gpio_out, 32'd0);
        chk("mid_rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        rd(A_TMR, F_W, "mid_rst_timer", 32'd0);
        rd(32'h20, F_W, "ram_kept", 32'h1122_3344);
        rd(A_STAT, F_W, "mid_rst_status", 32'h0000_0004);

        // Timer wrap with compare at all-ones
        wr(A_TMR, 32'hFFFF_FFFE, F_W);
        rd(A_TMR, F_W, "wrap_a", 32'hFFFF_FFFE);
        chk("wrap_irq0", {31'd0, timer_irq}, 32'd0);
        rd(A_TMR, F_W, "wrap_b", 32'hFFFF_FFFF);
        chk("wrap_irq1", {31'd0, timer_irq}, 32'd1);
        rd(A_TMR, F_W, "wrap_c", 32'h0000_0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
